// File: rtl/prewish_mask_arbiter_pkg.sv
// Shared definitions for the mask-load arbiter: FSM state encoding,
// default widths and the round-robin winner selection helper.
package prewish_mask_arbiter_pkg;

  localparam int MASK_W_DEFAULT       = 8;
  localparam int HOLDOFF_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Winner index for the pending strobes. When both requesters are pending,
  // favour1 decides (1 = req1 has first claim). Otherwise the single active
  // requester wins; the result is only used when at least one strobe is high.
  function automatic logic pick_winner(input logic stb0, input logic stb1,
                                       input logic favour1);
    if (stb0 && stb1) begin
      return favour1;
    end
    return stb1;
  endfunction

endpackage

// File: rtl/prewish_holdoff_timer.sv
// Load-and-count-down timer. A load arms the timer with all-ones; it then
// counts down once per cycle and raises done for exactly one cycle while the
// count sits at zero, after which it disarms until the next load.
module prewish_holdoff_timer #(
  parameter int HOLDOFF_BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [HOLDOFF_BITS-1:0] count;
  logic                    armed;

  // Count register: load to max, decrement while armed, disarm after zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= '1;
      armed <= 1'b1;
    end else if (armed) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end else begin
        armed <= 1'b0;
      end
    end
  end

  // Done pulse: the single armed cycle where the count has reached zero.
  always_comb begin
    done = armed && (count == '0);
  end

endmodule

// File: rtl/prewish_mask_arbiter.sv
// Arbitrates the blinky mask-load port between the manual path (req0) and
// the auto-pattern path (req1).
//
// Handshake: each requester raises STBx_I with DATx_I stable and holds both
// until it sees a one-cycle ACKx_O; dropping STB earlier withdraws the
// request. The winner's data is forwarded to the blinky as a one-cycle STB_O
// with DAT_O, and DAT_O then holds that mask until the next grant.
//
// Each grant is followed by 2^HOLDOFF_BITS hold-off cycles so mask updates
// cannot land back-to-back. All outputs decode registered state only.
module prewish_mask_arbiter
  import prewish_mask_arbiter_pkg::*;
#(
  parameter int MASK_W       = MASK_W_DEFAULT,
  parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEFAULT
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB0_I,
  input  logic [MASK_W-1:0] DAT0_I,
  output logic              ACK0_O,
  input  logic              STB1_I,
  input  logic [MASK_W-1:0] DAT1_I,
  output logic              ACK1_O,
  output logic              STB_O,
  output logic [MASK_W-1:0] DAT_O,
  output logic              o_busy,
  output logic              o_src,
  output state_t            dbg_state
);

  state_t            state;
  state_t            next_state;
  logic              winner_q;
  logic              favour1_q;
  logic [MASK_W-1:0] dat_q;
  logic              take_src;
  logic              take;
  logic              timer_load;
  logic              timer_done;

  // Winner selection among pending strobes, round-robin on collision.
  always_comb begin
    take_src = pick_winner(STB0_I, STB1_I, favour1_q);
    take     = (state == ST_IDLE) && (STB0_I || STB1_I);
  end

  // FSM state register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: IDLE -> GRANT (1 cycle) -> HOLDOFF -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (STB0_I || STB1_I) begin
          next_state = ST_GRANT;
        end
      end
      ST_GRANT: begin
        next_state = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (timer_done) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Grant capture: latch winner and its mask, hand first claim to the other.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      winner_q  <= 1'b0;
      favour1_q <= 1'b0;
      dat_q     <= '0;
    end else if (take) begin
      winner_q  <= take_src;
      favour1_q <= ~take_src;
      dat_q     <= take_src ? DAT1_I : DAT0_I;
    end
  end

  // FSM outputs decoded from registered state only.
  always_comb begin
    STB_O      = (state == ST_GRANT);
    ACK0_O     = (state == ST_GRANT) && !winner_q;
    ACK1_O     = (state == ST_GRANT) && winner_q;
    o_busy     = (state != ST_IDLE);
    o_src      = winner_q;
    DAT_O      = dat_q;
    dbg_state  = state;
    timer_load = (state == ST_GRANT);
  end

  prewish_holdoff_timer #(
    .HOLDOFF_BITS (HOLDOFF_BITS)
  ) u_holdoff (
    .clk  (CLK_I),
    .rst  (RST_I),
    .load (timer_load),
    .done (timer_done)
  );

endmodule
